// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - operand fetch ahead of the ALU: register file, writeback bypass,
// scoreboard hazard blocking and a registered valid/ready operand bundle
module alu_operand_stage #(
  parameter int NREG = 16,
  parameter int W    = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_op,
  input  logic [3:0]   in_rs,
  input  logic [3:0]   in_rt,
  input  logic [3:0]   in_rd,
  input  logic [4:0]   in_imm,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [4:0]   alu_imm,
  output logic [3:0]   out_rd,
  input  logic         wb_en,
  input  logic [3:0]   wb_addr,
  input  logic [W-1:0] wb_data
);

  logic [W-1:0]    regs_q [NREG];
  logic [W-1:0]    regs_d [NREG];
  logic [NREG-1:0] pending_q, pending_d, pend_live;
  logic            out_valid_q, out_valid_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic [W-1:0]    alu_a_q, alu_a_d;
  logic [W-1:0]    alu_b_q, alu_b_d;
  logic [4:0]      alu_imm_q, alu_imm_d;
  logic [3:0]      out_rd_q, out_rd_d;
  logic [W-1:0]    rs_val, rt_val;
  logic            wb_live, hazard, issue;

  always_comb begin
    wb_live = wb_en && (wb_addr != 4'd0);

    // Pending view after this cycle's writeback, so a producer retiring now unblocks its consumer.
    pend_live = pending_q;
    if (wb_live) pend_live[wb_addr] = 1'b0;

    if (in_rs == 4'd0)                     rs_val = '0;
    else if (wb_live && wb_addr == in_rs)  rs_val = wb_data;
    else                                   rs_val = regs_q[in_rs];

    if (in_rt == 4'd0)                     rt_val = '0;
    else if (wb_live && wb_addr == in_rt)  rt_val = wb_data;
    else                                   rt_val = regs_q[in_rt];

    hazard   = pend_live[in_rs] | pend_live[in_rt];
    in_ready = !hazard && (!out_valid_q || out_ready);
    issue    = in_valid && in_ready;

    // Applied after the clear so a new producer on the same register stays outstanding.
    pending_d = pend_live;
    if (issue && in_rd != 4'd0) pending_d[in_rd] = 1'b1;

    for (int i = 0; i < NREG; i++) regs_d[i] = regs_q[i];
    if (wb_live) regs_d[wb_addr] = wb_data;

    out_valid_d = out_valid_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_imm_d   = alu_imm_q;
    out_rd_d    = out_rd_q;
    if (issue) begin
      out_valid_d = 1'b1;
      alu_op_d    = in_op;
      alu_a_d     = rs_val;
      alu_b_d     = rt_val;
      alu_imm_d   = in_imm;
      out_rd_d    = in_rd;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_imm_q   <= '0;
      out_rd_q    <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_imm_q   <= alu_imm_d;
      out_rd_q    <= out_rd_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_imm   = alu_imm_q;
  assign out_rd    = out_rd_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - directed and randomized checks of alu_operand_stage against a reference model
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op, in_rs, in_rt, in_rd;
  logic [4:0]  in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic [15:0] alu_a, alu_b;
  logic [4:0]  alu_imm;
  logic [3:0]  out_rd;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;

  always #5 clk = ~clk;

  alu_operand_stage #(.NREG(16), .W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm), .out_rd(out_rd),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Architectural model: register values, outstanding writers, and the bundle the ALU should see.
  logic [15:0] m_regs [16];
  bit          m_pend [16];
  bit          m_valid;
  logic [3:0]  m_op, m_rd;
  logic [15:0] m_a, m_b;
  logic [4:0]  m_imm;
  logic        s_ready;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 0;
    end
    m_valid = 0; m_op = '0; m_rd = '0; m_a = '0; m_b = '0; m_imm = '0;
  endtask

  function automatic bit src_blocked(input logic [3:0] r, input logic wen, input logic [3:0] waddr);
    return (r != 0) && m_pend[r] && !(wen && waddr == r);
  endfunction

  function automatic logic [15:0] src_value(input logic [3:0] r, input logic wen,
                                            input logic [3:0] waddr, input logic [15:0] wdata);
    if (r == 0) return 16'h0;
    if (wen && waddr == r) return wdata;
    return m_regs[r];
  endfunction

  task automatic cycle(input logic v, input logic [3:0] op, input logic [3:0] rs,
                       input logic [3:0] rt, input logic [3:0] rd, input logic [4:0] imm,
                       input logic ordy, input logic wen, input logic [3:0] waddr,
                       input logic [15:0] wdata);
    bit exp_ready;
    @(negedge clk);
    in_valid = v; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
    out_ready = ordy; wb_en = wen; wb_addr = waddr; wb_data = wdata;
    #1;
    exp_ready = !(src_blocked(rs, wen, waddr) || src_blocked(rt, wen, waddr)) && (!m_valid || ordy);
    s_ready = in_ready;
    chk("in_ready", in_ready, exp_ready);
    chk("out_valid", out_valid, m_valid);
    chk("alu_op", alu_op, m_op);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_imm", alu_imm, m_imm);
    chk("out_rd", out_rd, m_rd);
    @(posedge clk);
    if (v && exp_ready) begin
      m_valid = 1;
      m_op = op; m_rd = rd; m_imm = imm;
      m_a = src_value(rs, wen, waddr, wdata);
      m_b = src_value(rt, wen, waddr, wdata);
    end else if (m_valid && ordy) begin
      m_valid = 0;
    end
    if (wen && waddr != 0) begin
      m_pend[waddr] = 0;
      m_regs[waddr] = wdata;
    end
    if (v && exp_ready && rd != 0) m_pend[rd] = 1;
  endtask

  task automatic idle(input logic ordy);
    cycle(0, 4'd0, 4'd0, 4'd0, 4'd0, 5'd0, ordy, 0, 4'd0, 16'h0);
  endtask

  initial begin
    logic [3:0] waddr;
    int         npend;
    logic [3:0] plist [$];

    rst_n = 1'b0;
    in_valid = 0; in_op = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_imm = 0;
    out_ready = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    model_reset();
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_alu_a", alu_a, 0);
    #10 rst_n = 1'b1;

    // First issue after reset.
    cycle(1, 4'd0, 4'd0, 4'd0, 4'd3, 5'd5, 1, 0, 4'd0, 16'h0);
    chk("first_ready", s_ready, 1);
    #2;
    chk("first_valid", out_valid, 1);
    chk("first_a", alu_a, 0);
    chk("first_b", alu_b, 0);
    chk("first_imm", alu_imm, 5);
    chk("first_rd", out_rd, 3);

    // RAW on r3: blocked until writeback, then bypassed value.
    cycle(1, 4'd1, 4'd3, 4'd0, 4'd4, 5'd0, 1, 0, 4'd0, 16'h0);
    chk("raw_stall0", s_ready, 0);
    cycle(1, 4'd1, 4'd3, 4'd0, 4'd4, 5'd0, 1, 0, 4'd0, 16'h0);
    chk("raw_stall1", s_ready, 0);
    cycle(1, 4'd1, 4'd3, 4'd0, 4'd4, 5'd0, 1, 1, 4'd3, 16'h1234);
    chk("raw_release", s_ready, 1);
    #2;
    chk("raw_bypass_a", alu_a, 16'h1234);

    // Register 0 is never written and never pending.
    cycle(0, 4'd0, 4'd0, 4'd0, 4'd0, 5'd0, 1, 1, 4'd0, 16'hFFFF);
    cycle(1, 4'd2, 4'd0, 4'd0, 4'd0, 5'd0, 1, 0, 4'd0, 16'h0);
    #2;
    chk("r0_read", alu_a, 0);
    cycle(1, 4'd2, 4'd0, 4'd0, 4'd0, 5'd1, 1, 0, 4'd0, 16'h0);
    chk("r0_no_stall", s_ready, 1);

    // Back-pressure: first bundle held, second loads when the ALU frees up.
    cycle(0, 4'd0, 4'd0, 4'd0, 4'd0, 5'd0, 1, 1, 4'd4, 16'h00AA);
    cycle(1, 4'd3, 4'd4, 4'd0, 4'd6, 5'd7, 0, 0, 4'd0, 16'h0);
    cycle(1, 4'd4, 4'd0, 4'd0, 4'd7, 5'd9, 0, 0, 4'd0, 16'h0);
    chk("bp_blocked", s_ready, 0);
    cycle(1, 4'd4, 4'd0, 4'd0, 4'd7, 5'd9, 0, 0, 4'd0, 16'h0);
    #2;
    chk("bp_hold_op", alu_op, 3);
    chk("bp_hold_a", alu_a, 16'h00AA);
    cycle(1, 4'd4, 4'd0, 4'd0, 4'd7, 5'd9, 1, 0, 4'd0, 16'h0);
    chk("bp_release", s_ready, 1);
    #2;
    chk("bp_b2b_valid", out_valid, 1);
    chk("bp_b2b_op", alu_op, 4);
    chk("bp_b2b_rd", out_rd, 7);

    // Set/clear collision on r5 keeps it pending.
    cycle(1, 4'd0, 4'd0, 4'd0, 4'd5, 5'd0, 1, 0, 4'd0, 16'h0);
    cycle(1, 4'd0, 4'd0, 4'd0, 4'd5, 5'd0, 1, 1, 4'd5, 16'h0055);
    cycle(1, 4'd0, 4'd5, 4'd0, 4'd0, 5'd0, 1, 0, 4'd0, 16'h0);
    chk("collide_pending", s_ready, 0);
    cycle(0, 4'd0, 4'd0, 4'd0, 4'd0, 5'd0, 1, 1, 4'd5, 16'h0056);

    // Randomized traffic; writebacks favour outstanding registers so nothing starves.
    for (int c = 0; c < 1500; c++) begin
      plist.delete();
      for (int r = 1; r < 16; r++) if (m_pend[r]) plist.push_back(r[3:0]);
      npend = plist.size();
      if (npend > 0 && ($urandom % 4) != 0) waddr = plist[$urandom % npend];
      else                                  waddr = 4'($urandom % 16);
      cycle(1'($urandom % 4 != 0), 4'($urandom), 4'($urandom % 8), 4'($urandom % 8),
            4'($urandom % 8), 5'($urandom), 1'($urandom % 4 != 0),
            1'($urandom % 2), waddr, 16'($urandom));
    end

    // Asynchronous reset while a bundle is stalled.
    idle(1);
    cycle(1, 4'd5, 4'd0, 4'd0, 4'd2, 5'd3, 0, 1, 4'd1, 16'hBEEF);
    idle(0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_op", alu_op, 0);
    chk("arst_a", alu_a, 0);
    chk("arst_b", alu_b, 0);
    chk("arst_imm", alu_imm, 0);
    chk("arst_rd", out_rd, 0);
    chk("arst_ready", in_ready, 1);
    model_reset();
    #1 rst_n = 1'b1;
    cycle(1, 4'd0, 4'd1, 4'd2, 4'd0, 5'd0, 1, 0, 4'd0, 16'h0);
    #2;
    chk("arst_reg1", alu_a, 0);
    chk("arst_reg2", alu_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
